// File: rtl/mem_pkg.sv
// Shared types and defaults for the I/D-cache memory arbiter.
package mem_pkg;

  localparam int unsigned ADDR_W_DEF = 28;
  localparam int unsigned DATA_W_DEF = 128;

  // Arbiter FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    TURN  = 2'd3
  } arb_state_t;

  // Last owner served, used for round-robin under contention.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Bit positions in the one-hot pick vector.
  localparam int unsigned PICK_I = 0;
  localparam int unsigned PICK_D = 1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: one-hot grant, alternates on contention.
module rr_pick2
  import mem_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  owner_t     last_gnt,
  output logic [1:0] gnt
);

  // Single requester wins outright; on contention the side not served last wins.
  always_comb begin
    gnt = '0;
    if (req_i && req_d) begin
      if (last_gnt == OWN_I) gnt[PICK_D] = 1'b1;
      else                   gnt[PICK_I] = 1'b1;
    end else if (req_i) begin
      gnt[PICK_I] = 1'b1;
    end else if (req_d) begin
      gnt[PICK_D] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between the I-cache and D-cache.
// Commands are latched at grant time; completion is a one-cycle ready pulse.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  // I-cache
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  // D-cache
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  // Shared memory
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  // Ownership flags
  output logic              gnt_i,
  output logic              gnt_d
);

  arb_state_t state_q;
  owner_t     last_gnt_q;
  logic [1:0] pick;
  logic       req_d_any;

  assign req_d_any = d_mem_read | d_mem_write;

  rr_pick2 u_pick (
    .req_i    (i_mem_read),
    .req_d    (req_d_any),
    .last_gnt (last_gnt_q),
    .gnt      (pick)
  );

  // Ready is qualified by the registered owner flag, so it can only pulse in GNT_x.
  assign i_mem_ready = mem_ready & gnt_i;
  assign d_mem_ready = mem_ready & gnt_d;
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

  // Arbiter FSM; all memory-side outputs and grant flags are registered here.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q    <= IDLE;
      last_gnt_q <= OWN_I;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      gnt_i      <= 1'b0;
      gnt_d      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick[PICK_D]) begin
            state_q   <= GNT_D;
            gnt_d     <= 1'b1;
            // Simultaneous read+write is treated as a write-back.
            mem_write <= d_mem_write;
            mem_read  <= d_mem_read & ~d_mem_write;
            mem_addr  <= d_mem_addr;
            mem_wdata <= d_mem_wdata;
          end else if (pick[PICK_I]) begin
            state_q   <= GNT_I;
            gnt_i     <= 1'b1;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
            mem_addr  <= i_mem_addr;
            mem_wdata <= '0;
          end
        end
        GNT_I, GNT_D: begin
          if (mem_ready) begin
            state_q    <= TURN;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            gnt_i      <= 1'b0;
            gnt_d      <= 1'b0;
            last_gnt_q <= (state_q == GNT_D) ? OWN_D : OWN_I;
          end
        end
        TURN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grants,
// a monitor pops and compares as grants and ready pulses appear.
module tb_mem_arbiter;

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 128;

  logic          clk = 1'b0;
  logic          proc_reset_n;
  logic          i_mem_read;
  logic [AW-1:0] i_mem_addr;
  logic [DW-1:0] i_mem_rdata;
  logic          i_mem_ready;
  logic          d_mem_read;
  logic          d_mem_write;
  logic [AW-1:0] d_mem_addr;
  logic [DW-1:0] d_mem_wdata;
  logic [DW-1:0] d_mem_rdata;
  logic          d_mem_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          gnt_i;
  logic          gnt_d;

  logic auto_ready;
  logic force_ready;
  logic resp_en;
  int   resp_lat;

  assign mem_ready = auto_ready | force_ready;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .i_mem_read   (i_mem_read),
    .i_mem_addr   (i_mem_addr),
    .i_mem_rdata  (i_mem_rdata),
    .i_mem_ready  (i_mem_ready),
    .d_mem_read   (d_mem_read),
    .d_mem_write  (d_mem_write),
    .d_mem_addr   (d_mem_addr),
    .d_mem_wdata  (d_mem_wdata),
    .d_mem_rdata  (d_mem_rdata),
    .d_mem_ready  (d_mem_ready),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .gnt_i        (gnt_i),
    .gnt_d        (gnt_d)
  );

  typedef struct {
    bit            is_d;
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            gap;   // required cycles since previous ready; 0 = unchecked
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   i_pulses = 0;
  int   d_pulses = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input bit is_d, input bit rd, input bit wr,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input int gap);
    exp_t e;
    e.is_d = is_d; e.rd = rd; e.wr = wr; e.addr = addr; e.wdata = wdata; e.gap = gap;
    return e;
  endfunction

  // Memory model: answers a pending command after resp_lat waiting cycles.
  initial begin
    int          cnt;
    int unsigned resp_n;
    cnt = 0;
    resp_n = 0;
    auto_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      auto_ready = 1'b0;
      if (resp_en && proc_reset_n && (mem_read || mem_write)) begin
        if (cnt == resp_lat) begin
          auto_ready = 1'b1;
          cnt = 0;
          resp_n++;
          mem_rdata = {4{32'hDA7A0000 | resp_n}};
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: compares each new grant and each memory completion.
  initial begin
    bit   have_owner;
    bit   owner_d;
    bit   prev_gnt;
    int   cyc;
    int   last_rdy_cyc;
    exp_t e;
    have_owner = 0; owner_d = 0; prev_gnt = 0; cyc = 0; last_rdy_cyc = 0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!proc_reset_n) begin
        have_owner = 0;
        prev_gnt = 0;
      end else begin
        if (i_mem_ready) i_pulses++;
        if (d_mem_ready) d_pulses++;
        if ((gnt_i || gnt_d) && !prev_gnt) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL grant_unexpected: got gnt_i=%0b gnt_d=%0b expected no grant", gnt_i, gnt_d);
          end else begin
            e = exp_q.pop_front();
            chk("grant_owner", {gnt_d, gnt_i}, e.is_d ? 2'b10 : 2'b01);
            chk("mem_read",  mem_read,  e.rd);
            chk("mem_write", mem_write, e.wr);
            chk("mem_addr",  mem_addr,  e.addr);
            chk("mem_wdata", mem_wdata, e.wdata);
            if (e.gap > 0) chk("turn_gap", cyc - last_rdy_cyc, e.gap);
            have_owner = 1;
            owner_d = e.is_d;
          end
        end
        prev_gnt = gnt_i || gnt_d;
        if (mem_ready) begin
          if (have_owner) begin
            chk("i_ready", i_mem_ready, !owner_d);
            chk("d_ready", d_mem_ready, owner_d);
            chk("rdata", owner_d ? d_mem_rdata : i_mem_rdata, mem_rdata);
            have_owner = 0;
            last_rdy_cyc = cyc;
          end else begin
            chk("spur_i_ready", i_mem_ready, 1'b0);
            chk("spur_d_ready", d_mem_ready, 1'b0);
          end
        end
      end
    end
  end

  // Waits (bounded) for cumulative ready-pulse totals, then checks them exactly.
  task automatic wait_pulses(input string name, input int ti, input int td);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #2;
      if (i_pulses >= ti && d_pulses >= td) break;
    end
    chk({name, "_i_pulses"}, i_pulses, ti);
    chk({name, "_d_pulses"}, d_pulses, td);
  endtask

  task automatic idle_checks(input string name);
    chk({name, "_mem_read"},  mem_read,  1'b0);
    chk({name, "_mem_write"}, mem_write, 1'b0);
    chk({name, "_gnt"},       {gnt_i, gnt_d}, 2'b00);
  endtask

  // Directed stimulus.
  initial begin
    proc_reset_n = 1'b0;
    i_mem_read = 1'b0; i_mem_addr = '0;
    d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_addr = '0; d_mem_wdata = '0;
    force_ready = 1'b0; resp_en = 1'b1; resp_lat = 3;

    // Reset holds everything low even with requests active.
    @(negedge clk);
    i_mem_read = 1'b1; d_mem_write = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    idle_checks("reset");
    chk("reset_addr",  mem_addr,  '0);
    chk("reset_wdata", mem_wdata, '0);
    chk("reset_ready", {i_mem_ready, d_mem_ready}, 2'b00);
    i_mem_read = 1'b0; d_mem_write = 1'b0;
    @(negedge clk);
    proc_reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // I read alone: one-cycle latency, single I pulse, no D pulse.
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 28'h0000010, '0, 0));
    i_mem_read = 1'b1; i_mem_addr = 28'h0000010;
    #2;
    chk("lat_before_edge", mem_read, 1'b0);
    @(negedge clk);
    #2;
    chk("lat_after_edge", mem_read, 1'b1);
    wait_pulses("iread", 1, 0);
    i_mem_read = 1'b0;
    repeat (4) @(negedge clk);

    // Contention right after reset: D write first, I after one TURN.
    proc_reset_n = 1'b0;
    @(negedge clk);
    proc_reset_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 28'h0000020, {16{8'hA5}}, 0));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 28'h0000030, '0, 3));
    i_mem_read = 1'b1; i_mem_addr = 28'h0000030;
    d_mem_write = 1'b1; d_mem_addr = 28'h0000020; d_mem_wdata = {16{8'hA5}};
    wait_pulses("contend_d", 1, 1);
    d_mem_write = 1'b0;
    wait_pulses("contend_i", 2, 1);
    i_mem_read = 1'b0;
    repeat (3) @(negedge clk);

    // Both held for four transactions: D, I, D, I.
    resp_lat = 1;
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 28'h0000040, {8{16'h1111}}, 0));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 28'h0000050, '0, 3));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 28'h0000040, {8{16'h1111}}, 3));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 28'h0000050, '0, 3));
    i_mem_read = 1'b1; i_mem_addr = 28'h0000050;
    d_mem_read = 1'b1; d_mem_addr = 28'h0000040; d_mem_wdata = {8{16'h1111}};
    wait_pulses("rr4", 4, 3);
    i_mem_read = 1'b0; d_mem_read = 1'b0;
    repeat (3) @(negedge clk);

    // D read+write together is latched as a write.
    resp_lat = 2;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 28'h0000060, {16{8'h5A}}, 0));
    d_mem_read = 1'b1; d_mem_write = 1'b1; d_mem_addr = 28'h0000060; d_mem_wdata = {16{8'h5A}};
    wait_pulses("rdwr", 4, 4);
    d_mem_read = 1'b0; d_mem_write = 1'b0;
    repeat (3) @(negedge clk);

    // Spurious mem_ready in IDLE.
    force_ready = 1'b1;
    @(negedge clk);
    force_ready = 1'b0;
    #2;
    idle_checks("spur_idle");
    chk("spur_i_total", i_pulses, 4);
    chk("spur_d_total", d_pulses, 4);
    repeat (2) @(negedge clk);

    // Reset while GNT_D waits on memory: abandoned, no later pulse.
    resp_en = 1'b0;
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 28'h0000070, {4{32'h0BADF00D}}, 0));
    d_mem_read = 1'b1; d_mem_addr = 28'h0000070; d_mem_wdata = {4{32'h0BADF00D}};
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #2;
      if (gnt_d) break;
    end
    chk("abort_gnt_d", gnt_d, 1'b1);
    @(negedge clk);
    #3;
    proc_reset_n = 1'b0;
    #1;
    idle_checks("abort_rst");
    chk("abort_addr",  mem_addr,  '0);
    chk("abort_wdata", mem_wdata, '0);
    d_mem_read = 1'b0;
    @(negedge clk);
    #2;
    proc_reset_n = 1'b1;
    @(negedge clk);
    force_ready = 1'b1;
    @(negedge clk);
    force_ready = 1'b0;
    #2;
    idle_checks("abort_after");
    chk("abort_i_total", i_pulses, 4);
    chk("abort_d_total", d_pulses, 4);
    repeat (3) @(negedge clk);

    chk("exp_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
